// File: rtl/regfile_2r1w.sv
// N x K register file with one bit-masked write port and two independent read ports.
// Supports synchronous clear, write-to-read bypass, hardwired-zero entry 0, and combinational or registered reads.
module regfile_2r1w #(
    parameter int K         = 16,
    parameter int N         = 8,
    parameter bit SYNC_READ = 1'b0,
    parameter bit BYPASS    = 1'b1,
    parameter bit ZERO_R0   = 1'b0,
    localparam int A        = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [K-1:0] wr_data,
    input  logic [K-1:0] wr_mask,
    input  logic         rd_en,
    input  logic [A-1:0] rd_addr_a,
    output logic [K-1:0] rd_data_a,
    input  logic [A-1:0] rd_addr_b,
    output logic [K-1:0] rd_data_b
);

    // One extra bit so that the depth itself fits when N is a power of two.
    localparam logic [A:0] DEPTH = (A + 1)'(N);

    logic [K-1:0] mem [N];

    logic         wr_hit;
    logic [K-1:0] stored_a, stored_b;
    logic [K-1:0] merged_a, merged_b;
    logic         match_a, match_b;
    logic [K-1:0] next_a, next_b;

    function automatic logic readable(input logic [A-1:0] addr);
        return ({1'b0, addr} < DEPTH) && !(ZERO_R0 && (addr == '0));
    endfunction

    assign wr_hit = wr_en && readable(wr_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (wr_hit) begin
            mem[wr_addr] <= (wr_data & wr_mask) | (mem[wr_addr] & ~wr_mask);
        end
    end

    assign stored_a = readable(rd_addr_a) ? mem[rd_addr_a] : '0;
    assign stored_b = readable(rd_addr_b) ? mem[rd_addr_b] : '0;

    // A bypass match implies rd_addr == wr_addr, so each port merges against its own stored word.
    assign merged_a = (wr_data & wr_mask) | (stored_a & ~wr_mask);
    assign merged_b = (wr_data & wr_mask) | (stored_b & ~wr_mask);

    assign match_a = BYPASS && wr_hit && !clear && (rd_addr_a == wr_addr);
    assign match_b = BYPASS && wr_hit && !clear && (rd_addr_b == wr_addr);

    assign next_a = match_a ? merged_a : stored_a;
    assign next_b = match_b ? merged_b : stored_b;

    generate
        if (SYNC_READ) begin : g_sync
            logic [K-1:0] reg_a, reg_b;

            // With bypass enabled a same-cycle clear is forwarded as zero.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    reg_a <= '0;
                    reg_b <= '0;
                end else if (rd_en) begin
                    reg_a <= (BYPASS && clear) ? '0 : next_a;
                    reg_b <= (BYPASS && clear) ? '0 : next_b;
                end
            end

            assign rd_data_a = reg_a;
            assign rd_data_b = reg_b;
        end else begin : g_comb
            logic unused_rd_en;
            assign unused_rd_en = rd_en;

            // Gated so a bypassed write cannot leak onto the outputs during reset.
            assign rd_data_a = reset ? next_a : '0;
            assign rd_data_b = reset ? next_b : '0;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: four instances share stimulus and cover
// combinational/bypass, combinational/no-bypass, registered read and zero-r0 with N=6.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] wr_mask;
    logic        rd_en;
    logic [2:0]  rd_addr_a, rd_addr_b;

    logic [15:0] comb_a, comb_b;
    logic [15:0] nobyp_a, nobyp_b;
    logic [15:0] sync_a, sync_b;
    logic [15:0] zero_a, zero_b;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.K(16), .N(8), .SYNC_READ(1'b0), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut_comb (
        .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_data_a(comb_a), .rd_addr_b(rd_addr_b), .rd_data_b(comb_b));

    regfile_2r1w #(.K(16), .N(8), .SYNC_READ(1'b0), .BYPASS(1'b0), .ZERO_R0(1'b0)) dut_nobyp (
        .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_data_a(nobyp_a), .rd_addr_b(rd_addr_b), .rd_data_b(nobyp_b));

    regfile_2r1w #(.K(16), .N(8), .SYNC_READ(1'b1), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut_sync (
        .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_data_a(sync_a), .rd_addr_b(rd_addr_b), .rd_data_b(sync_b));

    regfile_2r1w #(.K(16), .N(6), .SYNC_READ(1'b0), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut_zero (
        .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_data_a(zero_a), .rd_addr_b(rd_addr_b), .rd_data_b(zero_b));

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    // Drives one cycle's inputs just after the falling edge.
    task automatic applyStimulus(input logic cl, input logic we, input logic [2:0] wa,
                                 input logic [15:0] wd, input logic [15:0] wm,
                                 input logic re, input logic [2:0] ra, input logic [2:0] rb);
        @(negedge clk);
        clear     = cl;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        wr_mask   = wm;
        rd_en     = re;
        rd_addr_a = ra;
        rd_addr_b = rb;
        #1;
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;

        // Reset state on every address, both read styles
        #12;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(7 - i);
            #1;
            checkOutput($sformatf("reset_comb_a%0d", i), comb_a, 16'h0000);
            checkOutput($sformatf("reset_comb_b%0d", i), comb_b, 16'h0000);
        end
        checkOutput("reset_sync_a", sync_a, 16'h0000);
        checkOutput("reset_sync_b", sync_b, 16'h0000);
        @(negedge clk);
        reset = 1'b1;

        // Masked write sequence on address 3
        applyStimulus(0, 1, 3'd3, 16'hFFFF, 16'hFFFF, 0, 3'd3, 3'd3);
        checkOutput("byp_full_write", comb_a, 16'hFFFF);
        checkOutput("nobyp_full_write", nobyp_a, 16'h0000);
        applyStimulus(0, 1, 3'd3, 16'h1234, 16'h00FF, 0, 3'd3, 3'd3);
        checkOutput("byp_masked_merge", comb_a, 16'hFF34);
        checkOutput("nobyp_masked_old", nobyp_a, 16'hFFFF);
        applyStimulus(0, 1, 3'd3, 16'h0000, 16'h0000, 0, 3'd3, 3'd3);
        checkOutput("byp_zero_mask", comb_a, 16'hFF34);
        applyStimulus(0, 0, 3'd0, 16'h0000, 16'h0000, 0, 3'd3, 3'd3);
        checkOutput("masked_stored_a", comb_a, 16'hFF34);
        checkOutput("masked_stored_b", comb_b, 16'hFF34);
        checkOutput("nobyp_stored", nobyp_a, 16'hFF34);
        checkOutput("zero_stored3", zero_a, 16'hFF34);

        // Same-cycle bypass on address 5
        applyStimulus(0, 1, 3'd5, 16'hABCD, 16'hFFFF, 0, 3'd5, 3'd3);
        checkOutput("byp_addr5", comb_a, 16'hABCD);
        checkOutput("nobyp_addr5_old", nobyp_a, 16'h0000);
        checkOutput("byp_other_port", comb_b, 16'hFF34);
        applyStimulus(0, 0, 3'd0, 16'h0000, 16'h0000, 0, 3'd5, 3'd5);
        checkOutput("nobyp_addr5_new", nobyp_a, 16'hABCD);
        checkOutput("equal_addr_ports", comb_b, 16'hABCD);

        // Registered read: one-cycle latency, then hold with rd_en low
        applyStimulus(0, 1, 3'd2, 16'h0042, 16'hFFFF, 1, 3'd0, 3'd2);
        checkOutput("sync_no_early", sync_b, 16'h0000);
        afterEdge();
        checkOutput("sync_latency1", sync_b, 16'h0042);
        applyStimulus(0, 1, 3'd2, 16'h0099, 16'hFFFF, 0, 3'd0, 3'd2);
        afterEdge();
        checkOutput("sync_hold", sync_b, 16'h0042);
        checkOutput("comb_addr2", comb_b, 16'h0099);
        applyStimulus(0, 0, 3'd0, 16'h0000, 16'h0000, 1, 3'd3, 3'd2);
        afterEdge();
        checkOutput("sync_load_a", sync_a, 16'hFF34);
        checkOutput("sync_load_b", sync_b, 16'h0099);

        // Fill remaining entries, then clear against a simultaneous write
        applyStimulus(0, 1, 3'd1, 16'h1111, 16'hFFFF, 1, 3'd1, 3'd4);
        applyStimulus(0, 1, 3'd4, 16'h4444, 16'hFFFF, 1, 3'd1, 3'd4);
        applyStimulus(0, 0, 3'd0, 16'h0000, 16'h0000, 1, 3'd1, 3'd4);
        checkOutput("zero_fill1", zero_a, 16'h1111);
        checkOutput("zero_fill4", zero_b, 16'h4444);
        applyStimulus(1, 1, 3'd4, 16'hFFFF, 16'hFFFF, 1, 3'd4, 3'd2);
        checkOutput("clear_no_bypass", zero_a, 16'h4444);
        afterEdge();
        checkOutput("sync_clear_a", sync_a, 16'h0000);
        checkOutput("sync_clear_b", sync_b, 16'h0000);
        applyStimulus(0, 0, 3'd0, 16'h0000, 16'h0000, 1, 3'd4, 3'd2);
        for (int i = 0; i < 6; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(5 - i);
            #1;
            checkOutput($sformatf("clear_zero_a%0d", i), zero_a, 16'h0000);
            checkOutput($sformatf("clear_zero_b%0d", i), zero_b, 16'h0000);
        end
        checkOutput("clear_comb3", comb_a, 16'h0000);

        // Entry 0 hardwired in the zero-r0 instance, writable in the others
        applyStimulus(0, 1, 3'd0, 16'hBEEF, 16'hFFFF, 1, 3'd0, 3'd0);
        checkOutput("zero_r0_no_bypass", zero_a, 16'h0000);
        checkOutput("comb_r0_bypass", comb_a, 16'hBEEF);
        afterEdge();
        checkOutput("zero_r0_after", zero_b, 16'h0000);
        checkOutput("comb_r0_after", comb_b, 16'hBEEF);

        // Out-of-range write and read on the N=6 instance
        applyStimulus(0, 1, 3'd7, 16'h7777, 16'hFFFF, 1, 3'd7, 3'd6);
        checkOutput("oor_no_bypass", zero_a, 16'h0000);
        applyStimulus(0, 0, 3'd0, 16'h0000, 16'h0000, 1, 3'd7, 3'd6);
        checkOutput("oor_read7", zero_a, 16'h0000);
        checkOutput("oor_read6", zero_b, 16'h0000);
        checkOutput("inrange_addr7", comb_a, 16'h7777);
        for (int i = 0; i < 6; i++) begin
            rd_addr_a = 3'(i);
            #1;
            checkOutput($sformatf("oor_side_effect%0d", i), zero_a, 16'h0000);
        end

        // Asynchronous reset between edges during an active write
        applyStimulus(0, 1, 3'd1, 16'h5A5A, 16'hFFFF, 1, 3'd7, 3'd1);
        checkOutput("pre_reset_bypass", comb_b, 16'h5A5A);
        checkOutput("pre_reset_stored", comb_a, 16'h7777);
        reset = 1'b0;
        #1;
        checkOutput("async_reset_a", comb_a, 16'h0000);
        checkOutput("async_reset_b", comb_b, 16'h0000);
        checkOutput("async_reset_sync_a", sync_a, 16'h0000);
        reset = 1'b1;
        afterEdge();
        checkOutput("post_reset_sync_b", sync_b, 16'h5A5A);
        checkOutput("post_reset_sync_a", sync_a, 16'h0000);
        applyStimulus(0, 0, 3'd0, 16'h0000, 16'h0000, 0, 3'd7, 3'd1);
        checkOutput("post_reset_write", comb_b, 16'h5A5A);
        checkOutput("post_reset_cleared7", comb_a, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised multi-entry register file: N entries of K bits, one masked write port and two independent read ports (A, B).
- Next generation of the team's single load-enabled register. Adds depth, bit-masked writes, synchronous bulk clear, optional write-to-read bypass, optional hardwired-zero entry 0, and selectable combinational or registered reads.
- Used as the architectural register bank in datapath blocks.

Parameters:
- K, 16, data width in bits (>=1).
- N, 8, number of entries (>=2; need not be a power of two).
- A, $clog2(N), address width; derived, not overridden.
- SYNC_READ, 0, 0 = combinational read; 1 = registered read, 1-cycle latency.
- BYPASS, 1, 1 = a read of the entry being written returns the merged new data; 0 = read returns the old contents.
- ZERO_R0, 0, 1 = entry 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of all entries.
- wr_en  in  1  write enable.
- wr_addr  in  A  write address.
- wr_data  in  K  write data.
- wr_mask  in  K  per-bit write mask; 1 = update that bit.
- rd_en  in  1  read-register load enable; used only when SYNC_READ=1, ignored otherwise.
- rd_addr_a  in  A  port A address.
- rd_data_a  out  K  port A data.
- rd_addr_b  in  A  port B address.
- rd_data_b  out  K  port B data.

Behaviour:
- Reset: reset low asynchronously forces all entries and both read registers (SYNC_READ=1) to 0. Outputs read 0 while reset is low.
- Write: at a rising edge with wr_en=1 and wr_addr<N, stored bit i becomes wr_data[i] if wr_mask[i]=1, otherwise keeps its old value.
  - wr_mask all zero means no change.
  - wr_addr>=N is ignored with no side effects.
- ZERO_R0=1: writes to entry 0 are ignored and reads of entry 0 return 0 on both ports, regardless of bypass.
- Clear: at a rising edge with clear=1, all entries become 0. Clear has priority over a simultaneous write, so the write is lost.
- Out-of-range read (addr>=N): returns 0.
- Merged value M = (wr_data & wr_mask) | (stored & ~wr_mask). A bypass match requires wr_en=1, clear=0, wr_addr<N, rd_addr==wr_addr, and not (ZERO_R0 and addr 0).
- SYNC_READ=0 (combinational, 0 latency):
  - rd_data = stored[rd_addr].
  - BYPASS=1 with a match: rd_data = M in the same cycle.
- SYNC_READ=1 (registered, 1-cycle latency):
  - At a rising edge with rd_en=1, the read register loads stored[rd_addr] as sampled before the edge.
  - BYPASS=1 with a match: loads M instead.
  - BYPASS=1 with clear=1 that cycle: loads 0.
  - BYPASS=0: always loads the pre-edge value, including during clear.
  - rd_en=0: read register holds its value.
- Ports A and B are fully independent. Equal addresses return identical data.
- Reset asserted mid-operation overrides clear, write and read in the same cycle. The first edge after reset deasserts behaves normally.

Test Plan:
- Reset then read, K=16, N=8: assert reset low, then read all 8 entries on both ports -> all 0x0000, both SYNC_READ settings.
- Masked write: write 0xFFFF to addr 3, then write wr_data=0x1234, mask=0x00FF to addr 3 -> reads 0xFF34; mask=0x0000 -> still 0xFF34.
- Bypass, SYNC_READ=0: same cycle wr_addr=5 (0xABCD, full mask), rd_addr_a=5 -> BYPASS=1 gives 0xABCD in that cycle; BYPASS=0 gives old value 0x0000.
- Registered read, SYNC_READ=1:
  - Write 0x0042 to addr 2, rd_en=1, rd_addr_b=2 -> rd_data_b=0x0042 one cycle later.
  - Then rd_en=0 and write 0x0099 to addr 2 -> rd_data_b holds 0x0042.
- Clear vs write, ZERO_R0=1, N=6: fill entries 1-5 with nonzero values, then assert clear with wr_en=1 to addr 4 -> all read 0. Write to addr 0 -> reads 0. wr_addr=7 -> ignored; rd_addr=7 -> 0.
- Async reset mid-write: pulse reset low between edges while wr_en=1 -> outputs drop to 0 immediately with no clk edge; a write on the first edge after release lands normally.
